// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_rr_arbiter                                                  |
// | Purpose  : Round-robin share of one APB master port among NUM_REQ clients. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module apb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic                      pwrite_o,
  output logic [DATA_W-1:0]         pwdata_o,
  input  logic [DATA_W-1:0]         prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W:0]   c_NUM_REQ  = (IDX_W+1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_owner;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [NUM_REQ-1:0]  r_gnt;

  logic [ADDR_W-1:0]   w_addr  [NUM_REQ];
  logic [DATA_W-1:0]   w_wdata [NUM_REQ];
  logic [NUM_REQ-1:0]  w_rot;
  logic [IDX_W-1:0]    w_off;
  logic [IDX_W:0]      w_sum;
  logic [IDX_W-1:0]    w_sel;
  logic [NUM_REQ-1:0]  w_sel_oh;
  logic [IDX_W:0]      w_ptr_inc;
  logic [IDX_W-1:0]    w_next_ptr;
  logic                w_any;
  logic                w_access;
  logic                w_expire;
  logic                w_finish;

  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign w_addr[k]  = req_addr_i[k*ADDR_W +: ADDR_W];
      assign w_wdata[k] = req_wdata_i[k*DATA_W +: DATA_W];
    end
  endgenerate

  // Rotate so bit j means requester (ptr + j) mod NUM_REQ; lowest set bit wins.
  assign w_rot = NUM_REQ'({req_i, req_i} >> r_ptr);
  assign w_any = |req_i;

  always_comb begin
    w_off = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_off = IDX_W'(j);
      end
    end
  end

  assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_sel      = (w_sum >= c_NUM_REQ) ? IDX_W'(w_sum - c_NUM_REQ) : w_sum[IDX_W-1:0];
  assign w_sel_oh   = NUM_REQ'(1) << w_sel;
  assign w_ptr_inc  = {1'b0, r_owner} + (IDX_W+1)'(1);
  assign w_next_ptr = (w_ptr_inc == c_NUM_REQ) ? '0 : w_ptr_inc[IDX_W-1:0];

  assign w_access = (r_state == S_ACCESS);
  assign w_expire = (r_cnt == c_CNT_LAST);
  assign w_finish = w_access && (pready_i || w_expire);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_gnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state  <= S_SETUP;
            r_owner  <= w_sel;
            r_paddr  <= w_addr[w_sel];
            r_pwdata <= w_wdata[w_sel];
            r_pwrite <= req_write_i[w_sel];
            r_gnt    <= w_sel_oh;
            r_psel   <= 1'b1;
            r_cnt    <= '0;
          end
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
          r_cnt     <= '0;
        end
        S_ACCESS: begin
          // Bus fields return to zero with the transfer so IDLE shows a quiet port.
          if (w_finish) begin
            r_state   <= S_IDLE;
            r_ptr     <= w_next_ptr;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_gnt     <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign psel_o    = r_psel;
  assign penable_o = r_penable;
  assign paddr_o   = r_paddr;
  assign pwrite_o  = r_pwrite;
  assign pwdata_o  = r_pwdata;
  assign gnt_o     = r_gnt;

  assign done_o  = w_finish ? r_gnt : '0;
  assign rdata_o = (w_access && pready_i && !r_pwrite) ? prdata_i : '0;
  assign err_o   = w_access && (pready_i ? pslverr_i : w_expire);

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_arbiter.sv
`default_nettype none
// Randomized bench for apb_rr_arbiter against a transaction-level model,
// plus directed sequences with hand-computed expectations.
module tb_apb_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              pclk = 1'b0;
  logic              preset_n;
  logic [N-1:0]      req_i, req_write_i;
  logic [N*AW-1:0]   req_addr_i;
  logic [N*DW-1:0]   req_wdata_i;
  logic [N-1:0]      gnt_o, done_o;
  logic [DW-1:0]     rdata_o;
  logic              err_o, psel_o, penable_o, pwrite_o;
  logic [AW-1:0]     paddr_o;
  logic [DW-1:0]     pwdata_o;
  logic [DW-1:0]     prdata_i;
  logic              pready_i, pslverr_i;

  always #5 pclk = ~pclk;

  apb_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_i(req_i), .req_write_i(req_write_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  // Model: a transfer is "busy" from grant; m_t = 0 is the setup cycle, m_t >= 1 the k-th access cycle.
  bit            m_busy;
  int            m_t, m_owner, m_ptr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            m_write;
  logic [N-1:0]  exp_done, just_done, pend;
  bit            hold_all;
  int            stall;
  int            n_checks = 0;
  int            n_fail = 0;

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk();
    bit acc, fin;
    logic [N-1:0] e_gnt;
    @(negedge pclk);
    acc      = m_busy && (m_t >= 1);
    fin      = acc && (pready_i || (m_t == TO));
    e_gnt    = m_busy ? oh(m_owner) : '0;
    exp_done = fin ? oh(m_owner) : '0;
    check("psel",    psel_o,    m_busy);
    check("penable", penable_o, acc);
    check("gnt",     gnt_o,     e_gnt);
    check("paddr",   paddr_o,   m_busy ? m_addr : '0);
    check("pwdata",  pwdata_o,  m_busy ? m_wdata : '0);
    check("pwrite",  pwrite_o,  m_busy && m_write);
    check("done",    done_o,    exp_done);
    check("rdata",   rdata_o,   (acc && pready_i && !m_write) ? prdata_i : '0);
    check("err",     err_o,     acc && (pready_i ? pslverr_i : (m_t == TO)));
  endtask

  task automatic adv();
    int best, bestd, d;
    @(posedge pclk);
    if (m_busy) begin
      if (exp_done != '0) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end else begin
        m_t++;
      end
    end else if (req_i != '0) begin
      best  = 0;
      bestd = N;
      for (int k = 0; k < N; k++) begin
        d = (k - m_ptr + N) % N;
        if (req_i[k] && d < bestd) begin
          bestd = d;
          best  = k;
        end
      end
      m_busy  = 1;
      m_t     = 0;
      m_owner = best;
      m_addr  = req_addr_i[best*AW +: AW];
      m_wdata = req_wdata_i[best*DW +: DW];
      m_write = req_write_i[best];
    end
    just_done = exp_done;
    #1;
    for (int k = 0; k < N; k++) begin
      if (just_done[k]) begin
        pend[k]  = hold_all;
        req_i[k] = hold_all;
      end
    end
  endtask

  task automatic raise(input int k, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_i[k]                = 1'b1;
    pend[k]                 = 1'b1;
    req_write_i[k]          = wr;
    req_addr_i[k*AW +: AW]  = a;
    req_wdata_i[k*DW +: DW] = d;
  endtask

  task automatic do_reset();
    #2;
    preset_n = 1'b0;
    #1;
    check("rst_psel",    psel_o,    0);
    check("rst_penable", penable_o, 0);
    check("rst_done",    done_o,    0);
    check("rst_gnt",     gnt_o,     0);
    m_busy = 0; m_ptr = 0; m_t = 0; m_owner = 0;
    exp_done = '0; just_done = '0; pend = '0; req_i = '0; hold_all = 0;
    pready_i = 1'b0; pslverr_i = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    preset_n = 1'b1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    hold_all = 0;
    while ((m_busy || pend != '0) && g < 300) begin
      adv();
      pready_i  = 1'b1;
      pslverr_i = 1'b0;
      chk();
      g++;
    end
    check("drain_bound", (m_busy || pend != '0), 0);
  endtask

  task automatic rand_drive();
    for (int k = 0; k < N; k++) begin
      if (!pend[k] && !just_done[k]) begin
        req_write_i[k]          = 1'($urandom_range(0, 1));
        req_addr_i[k*AW +: AW]  = $urandom;
        req_wdata_i[k*DW +: DW] = $urandom;
        if ($urandom_range(0, 3) == 0) begin
          req_i[k] = 1'b1;
          pend[k]  = 1'b1;
        end
      end else if (pend[k] && m_busy && m_owner == k) begin
        // Owner-side changes mid-transfer must not reach the bus.
        if ($urandom_range(0, 7) == 0) req_i[k] = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          req_addr_i[k*AW +: AW]  = $urandom;
          req_wdata_i[k*DW +: DW] = $urandom;
          req_write_i[k]          = 1'($urandom_range(0, 1));
        end
      end
    end
    if (stall > 0) begin
      pready_i = 1'b0;
      stall--;
    end else begin
      if ($urandom_range(0, 39) == 0) stall = TO + 2;
      pready_i = ($urandom_range(0, 2) != 0);
    end
    pslverr_i = ($urandom_range(0, 5) == 0);
    prdata_i  = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    preset_n = 1'b0;
    req_i = '0; req_write_i = '0; req_addr_i = '0; req_wdata_i = '0;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0; stall = 0;
    do_reset();

    // Single write, zero wait states
    raise(0, 1'b1, 32'h0000_A000, 32'h0000_1234);
    pready_i = 1'b1;
    chk();
    check("t1_idle_psel", psel_o, 0);
    adv(); chk();
    check("t1_setup_gnt", gnt_o, 4'b0001);
    check("t1_setup_pen", penable_o, 0);
    check("t1_setup_addr", paddr_o, 32'h0000_A000);
    adv(); chk();
    check("t1_acc_done", done_o, 4'b0001);
    check("t1_acc_err", err_o, 0);
    check("t1_acc_wdata", pwdata_o, 32'h0000_1234);
    adv(); chk();
    check("t1_back_idle", psel_o, 0);

    // Read from requester 2 with three wait states
    adv();
    raise(2, 1'b0, 32'h0000_2040, 32'h0);
    pready_i = 1'b0;
    prdata_i = 32'h0;
    chk();
    adv(); chk();
    check("t2_setup_gnt", gnt_o, 4'b0100);
    for (int i = 1; i <= 4; i++) begin
      adv();
      if (i == 4) begin
        pready_i = 1'b1;
        prdata_i = 32'h0000_CAFE;
      end
      chk();
      check("t2_psel", psel_o, 1);
      check("t2_paddr", paddr_o, 32'h0000_2040);
      check("t2_done", done_o, (i == 4) ? 4'b0100 : 4'b0000);
      if (i == 4) check("t2_rdata", rdata_o, 32'h0000_CAFE);
    end
    adv(); chk();

    // Fairness from reset: all four held high
    do_reset();
    hold_all = 1;
    pready_i = 1'b1;
    for (int k = 0; k < N; k++) raise(k, 1'b1, 32'h100 * (k + 1), 32'h11 * (k + 1));
    chk();
    for (int i = 0; i < 8; i++) begin
      adv(); chk();
      check("t3_gnt_order", gnt_o, oh(i % 4));
      adv(); chk();
      check("t3_done_order", done_o, oh(i % 4));
      adv(); chk();
      check("t3_idle_gap", psel_o, 0);
    end
    drain();

    // Serve 1, then 0 and 2 together: 2 must go first
    adv();
    raise(1, 1'b1, 32'h0000_0111, 32'h0000_0001);
    chk();
    adv(); chk();
    check("t4_gnt1", gnt_o, 4'b0010);
    adv(); chk();
    adv();
    raise(0, 1'b0, 32'h0000_0000, 32'h0);
    raise(2, 1'b1, 32'h0000_0222, 32'h0000_0002);
    chk();
    adv(); chk();
    check("t4_gnt2_first", gnt_o, 4'b0100);
    adv(); chk();
    adv(); chk();
    adv(); chk();
    check("t4_gnt0_second", gnt_o, 4'b0001);
    adv(); chk();
    adv(); chk();

    // Timeout on requester 3
    adv();
    raise(3, 1'b0, 32'h0000_3000, 32'h0);
    pready_i = 1'b0;
    prdata_i = 32'hDEAD_BEEF;
    chk();
    adv(); chk();
    for (int i = 1; i <= TO; i++) begin
      adv(); chk();
      check("t5_to_done", done_o, (i == TO) ? 4'b1000 : 4'b0000);
      check("t5_to_err", err_o, (i == TO));
      check("t5_to_rdata", rdata_o, 0);
    end
    adv(); chk();
    check("t5_idle", psel_o, 0);
    // Pointer now 0: requester 0 beats 3; slave error on a ready cycle
    adv();
    raise(0, 1'b0, 32'h0000_0040, 32'h0);
    raise(3, 1'b1, 32'h0000_3004, 32'h0000_0033);
    pready_i  = 1'b1;
    pslverr_i = 1'b1;
    prdata_i  = 32'h5555_0000;
    chk();
    adv(); chk();
    check("t5_ptr_adv_gnt", gnt_o, 4'b0001);
    adv(); chk();
    check("t5_slverr_err", err_o, 1);
    check("t5_slverr_done", done_o, 4'b0001);
    check("t5_slverr_rdata", rdata_o, 32'h5555_0000);
    drain();

    // Reset in the second wait cycle of an access
    adv();
    raise(1, 1'b1, 32'h0000_0999, 32'h0000_0099);
    pready_i = 1'b0;
    chk();
    adv(); chk();
    adv(); chk();
    adv(); chk();
    check("t6_pre_rst_pen", penable_o, 1);
    do_reset();
    raise(3, 1'b1, 32'h0000_0888, 32'h0000_0088);
    pready_i = 1'b1;
    chk();
    check("t6_post_idle_done", done_o, 0);
    adv(); chk();
    check("t6_gnt3", gnt_o, 4'b1000);
    adv(); chk();
    check("t6_done3", done_o, 4'b1000);
    adv(); chk();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      adv();
      rand_drive();
      chk();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
